trace_capture: RTL
==================

# trace_capture

Hardware capture buffer that records one probe word per valid cycle from a MIPS datapath element (e.g. `{reset, d, y}` of a pipeline register) into an internal array. It plays the writer role opposite the vector-reading self-checking benches: captured words stream back out in order over a valid/ready port, so a host, UART bridge or bench can dump them in the same bit order as a `.tv` vector line. It sits beside the datapath on the shared `clk`/`reset`.

## Interface
- `WIDTH`, 5: bits per probe word, MSB first as in a vector line.
- `DEPTH`, 8: number of words the buffer holds; ≥2, power of two.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `arm`  in  1: start-capture pulse; honoured only in IDLE.
- `stop`  in  1: end capture early; honoured only in CAPTURE.
- `sample_valid`  in  1: `sample` is valid this cycle.
- `sample`  in  WIDTH: probe word.
- `busy`  out  1: high in CAPTURE.
- `done`  out  1: high in READOUT.
- `count`  out  $clog2(DEPTH+1): words captured in the current/last capture.
- `rd_valid`  out  1: `rd_data` holds a captured word.
- `rd_data`  out  WIDTH: word at the read pointer; 0 when `rd_valid` is low.
- `rd_last`  out  1: current word is the final captured word.
- `rd_ready`  in  1: consumer accepts `rd_data`.

## Operation
- States: IDLE, CAPTURE, READOUT.
- IDLE: `arm` → CAPTURE; write pointer, read pointer and `count` cleared to 0. `sample_valid`, `stop` and `rd_ready` ignored.
- CAPTURE: each cycle with `sample_valid` writes `sample` at the write pointer, then increments the pointer and `count`.
  - Write at index DEPTH-1 → READOUT.
  - `stop` with `count` > 0 → READOUT.
  - `stop` with `count` == 0 and no valid sample that cycle → IDLE; `done` never asserts.
  - `stop` and `sample_valid` in the same cycle: the sample is written first and included in `count`, then → READOUT.
  - `arm` ignored.
- READOUT: `rd_valid` = 1 and `rd_data` = mem[read pointer].
  - `rd_last` = (read pointer == `count`-1).
  - Transfer on `rd_valid & rd_ready` advances the read pointer.
  - Transfer with `rd_last` high → IDLE.
  - Without `rd_ready`, `rd_data`, `rd_last` and the read pointer hold.
  - `arm`, `stop` and `sample_valid` ignored.
- `count` holds its value in IDLE until the next `arm`.
- Pointers do not wrap; capture always ends at DEPTH words.
- Reset, from any state: state IDLE, pointers and `count` 0. Array contents are not reset.

## Timing
- Reset values: `busy` 0, `done` 0, `count` 0, `rd_valid` 0, `rd_data` 0, `rd_last` 0.
- `arm` sampled at edge n → `busy` high after edge n. The first sample can be accepted at edge n+1.
- The write at edge k that fills the buffer, or the accepted `stop` at edge k → `busy` low and `done`/`rd_valid` high after edge k. First word available in that same cycle; no extra read latency.
- `rd_data` is a combinational read of the array at the registered read pointer.
- Throughput: one word per cycle in each direction.
- `count` updates one edge after each write.

## Structure
- Package `trace_pkg`: `trace_state_t` enum (IDLE, CAPTURE, READOUT) and default-parameter constants.
- Sub-module `trace_mem`: DEPTH×WIDTH register array with one synchronous write port and one combinational read port. No reset on the array.
- `trace_capture` holds the FSM, pointers and `count`.

## Test plan
- Reset with all inputs active → all outputs 0 on the next cycle; `arm` one cycle later is accepted.
- `arm`, then 8 consecutive valid samples 5'b00000..5'b00111 → `busy` drops and `done` rises after the 8th write, `count`=8. With `rd_ready`=1 the port outputs 0..7 on consecutive cycles, `rd_last` only with 5'b00111, then IDLE.
- `arm`, then samples 5'b10101, gap, 5'b01010, then 5'b11111 together with `stop` → `count`=3; readout 10101, 01010, 11111 with `rd_last` on the third.
- Backpressure: full capture, `rd_ready` toggling 1,0,0,1… → each word held stable while `rd_ready`=0; no word lost or duplicated.
- `arm` pulsed during CAPTURE and `sample_valid` pulsed during IDLE → no effect on `count` or pointers. `stop` with `count`=0 → IDLE, `done` never high.
- `reset` asserted mid-readout after 3 transfers → next cycle IDLE, `rd_valid` 0, `count` 0. A new capture of 2 words reads back only those 2.

Source files
------------

// File: rtl/trace_capture_pkg.sv
// Shared types and default sizes for the trace capture buffer.
package trace_pkg;

    localparam int unsigned DefWidth = 5;
    localparam int unsigned DefDepth = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StReadout = 2'd2
    } trace_state_t;

endpackage

// File: rtl/trace_capture_if.sv
// Capture control plus valid/ready readout stream of the trace buffer.
interface trace_capture_if #(
    parameter int unsigned WIDTH = trace_pkg::DefWidth,
    parameter int unsigned DEPTH = trace_pkg::DefDepth
) ();
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic             arm;
    logic             stop;
    logic             sample_valid;
    logic [WIDTH-1:0] sample;
    logic             busy;
    logic             done;
    logic [CntW-1:0]  count;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;
    logic             rd_ready;

    modport master (
        output arm, stop, sample_valid, sample, rd_ready,
        input  busy, done, count, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  arm, stop, sample_valid, sample, rd_ready,
        output busy, done, count, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/trace_capture_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module trace_mem #(
    parameter int unsigned WIDTH = trace_pkg::DefWidth,
    parameter int unsigned DEPTH = trace_pkg::DefDepth,
    parameter int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AddrW-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AddrW-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; only words below count are ever read.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/trace_capture.sv
// Trace capture buffer: records one probe word per valid cycle, then streams them out in order.
module trace_capture
    import trace_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic            i_clk,
    input  logic            i_reset,
    trace_capture_if.slave  io_trace
);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    trace_state_t     r_state, w_state_d;
    logic [AddrW-1:0] r_wr_ptr, w_wr_ptr_d;
    logic [AddrW-1:0] r_rd_ptr, w_rd_ptr_d;
    logic [CntW-1:0]  r_count, w_count_d;
    logic             w_we;
    logic             w_rd_valid;
    logic             w_rd_last;
    logic [WIDTH-1:0] w_mem_rdata;

    assign w_rd_valid = (r_state == StReadout);
    assign w_rd_last  = w_rd_valid && (CntW'(r_rd_ptr) == r_count - CntW'(1));

    always_comb begin
        w_state_d  = r_state;
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_count_d  = r_count;
        w_we       = 1'b0;
        case (r_state)
            StIdle: begin
                if (io_trace.arm) begin
                    w_state_d  = StCapture;
                    w_wr_ptr_d = '0;
                    w_rd_ptr_d = '0;
                    w_count_d  = '0;
                end
            end
            StCapture: begin
                if (io_trace.sample_valid) begin
                    w_we       = 1'b1;
                    w_wr_ptr_d = r_wr_ptr + AddrW'(1);
                    w_count_d  = r_count + CntW'(1);
                    if (r_wr_ptr == AddrW'(DEPTH - 1)) begin
                        w_state_d = StReadout;
                    end
                end
                // A same-cycle sample counts, so stop then always has something to read.
                if (io_trace.stop) begin
                    if (io_trace.sample_valid || (r_count != '0)) begin
                        w_state_d = StReadout;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            StReadout: begin
                if (io_trace.rd_ready) begin
                    if (w_rd_last) begin
                        w_state_d = StIdle;
                    end else begin
                        w_rd_ptr_d = r_rd_ptr + AddrW'(1);
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_count  <= w_count_d;
        end
    end

    trace_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AddrW (AddrW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (io_trace.sample),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    assign io_trace.busy     = (r_state == StCapture);
    assign io_trace.done     = w_rd_valid;
    assign io_trace.count    = r_count;
    assign io_trace.rd_valid = w_rd_valid;
    assign io_trace.rd_data  = w_rd_valid ? w_mem_rdata : '0;
    assign io_trace.rd_last  = w_rd_last;
endmodule
